// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
// Holds the FSM state encoding, SPI_Wrapper opcodes and the bit-counter sizing helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SHIFT,
    WAIT,
    CAPT,
    DONE
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // Counter must hold the longest phase length of any state it times.
  function automatic int cnt_width(input int frame_w, input int data_w, input int rd_wait);
    int m;
    m = (frame_w > data_w) ? frame_w : data_w;
    if (rd_wait > m) m = rd_wait;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_shreg.sv
// Parallel-load / shift-left register with serial input.
// Bit W-1 is the first bit to leave; new serial bits enter at bit 0.
module spi_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] sh_d;
  logic [W-1:0] sh_q;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = {sh_q[W-2:0], sin};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q = sh_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: serialises one command frame MSB-first on MOSI and,
// for read-data commands, captures the slave's reply byte from MISO.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] cmd_din,
  output logic               ready,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               MOSI,
  output logic               SS_n,
  input  logic               MISO
);

  localparam int CNT_W = cnt_width(FRAME_W, DATA_W, RD_WAIT);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] CAPT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               is_rd_d, is_rd_q;
  logic               ss_n_d, ss_n_q;
  logic               mosi_d, mosi_q;
  logic               ready_d, ready_q;
  logic               rd_valid_d, rd_valid_q;
  logic [DATA_W-1:0]  rd_data_d, rd_data_q;

  logic               tx_load;
  logic               tx_shift;
  logic               rx_shift;
  logic [FRAME_W-1:0] tx_q;
  logic [DATA_W-1:0]  rx_q;
  logic               unused_bits;

  spi_shreg #(
    .W(FRAME_W)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tx_load),
    .din  (cmd_din),
    .shift(tx_shift),
    .sin  (1'b0),
    .q    (tx_q)
  );

  spi_shreg #(
    .W(DATA_W)
  ) u_rx (
    .clk  (clk),
    .rst_n(rst_n),
    .load (1'b0),
    .din  ('0),
    .shift(rx_shift),
    .sin  (MISO),
    .q    (rx_q)
  );

  // Lower TX bits only ever leave through the MSB; RX MSB is superseded by the final MISO bit.
  assign unused_bits = ^{tx_q[FRAME_W-2:0], rx_q[DATA_W-1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_rd_d    = is_rd_q;
    ss_n_d     = 1'b0;
    mosi_d     = 1'b0;
    ready_d    = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    rx_shift   = 1'b0;

    case (state_q)
      IDLE: begin
        ss_n_d  = 1'b1;
        ready_d = 1'b1;
        cnt_d   = '0;
        if (start) begin
          state_d = SEL;
          ss_n_d  = 1'b0;
          ready_d = 1'b0;
          mosi_d  = cmd_din[FRAME_W-1];
          tx_load = 1'b1;
          is_rd_d = (cmd_din[FRAME_W-1 -: 2] == OP_RD_DATA);
        end
      end

      // The TX MSB is emitted again as the first SHIFT bit, so shifting starts here.
      SEL: begin
        state_d  = SHIFT;
        cnt_d    = SHIFT_LAST;
        mosi_d   = tx_q[FRAME_W-1];
        tx_shift = 1'b1;
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - CNT_ONE;
          mosi_d   = tx_q[FRAME_W-1];
          tx_shift = 1'b1;
        end else if (is_rd_q) begin
          if (RD_WAIT > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LAST;
          end else begin
            state_d = CAPT;
            cnt_d   = CAPT_LAST;
          end
        end else begin
          state_d = DONE;
          ss_n_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = CAPT;
          cnt_d   = CAPT_LAST;
        end
      end

      // rd_data takes the completed byte on the same edge that enters DONE, so it is valid with rd_valid.
      CAPT: begin
        rx_shift = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d    = DONE;
          ss_n_d     = 1'b1;
          cnt_d      = '0;
          rd_valid_d = 1'b1;
          rd_data_d  = {rx_q[DATA_W-2:0], MISO};
        end
      end

      DONE: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        ready_d = 1'b1;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        ready_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_rd_q    <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_rd_q    <= is_rd_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;
  assign ready    = ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
